// File: rtl/filter_capture_ctrl.sv
// One-shot frame capture sequencer between the edge-filter output and the frame-buffer write port.
// Optional edge-pixel statistics are built when CAPTURE_STATS_EN is defined.
module filter_capture_ctrl #(
    parameter int unsigned H_RES       = 172,
    parameter int unsigned V_RES       = 320,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned TIMEOUT_CYC = 2000000,
    parameter int unsigned EDGE_TH     = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    input  logic              i_vsync,
    input  logic              i_hsync,
    input  logic              i_de,
    input  logic [7:0]        i_data,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic [7:0]        o_wdata,
    output logic [ADDR_W-1:0] o_edge_cnt
);

    localparam int unsigned NPIX = H_RES * V_RES;
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, ARM, CAPTURE, DONE, ERR} state_t;

    state_t            state_q, state_d;
    logic              vs_q, vs_qq;
    logic [ADDR_W-1:0] cnt_q;
    logic [WD_W-1:0]   wdog_q;
    logic              vs_rise, wd_exp, last_pix, start_ok;

    // Edge detected one register later so a rising vsync reaches CAPTURE two cycles after it appears.
    assign vs_rise  = vs_q & ~vs_qq;
    assign wd_exp   = (wdog_q == WD_W'(TIMEOUT_CYC - 1));
    assign last_pix = i_de && (cnt_q == ADDR_W'(NPIX - 1));
    assign start_ok = (state_q == IDLE) && i_start;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = ARM;
            ARM:     if (wd_exp) state_d = ERR;
                     else if (vs_rise) state_d = CAPTURE;
            CAPTURE: if (last_pix) state_d = DONE;
                     else if (vs_rise || (!i_de && wd_exp)) state_d = ERR;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Busy stays up through the DONE/ERR cycle so it falls together with o_done / o_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vs_q    <= 1'b0;
            vs_qq   <= 1'b0;
            cnt_q   <= '0;
            wdog_q  <= '0;
            o_busy  <= 1'b0;
            o_done  <= 1'b0;
            o_err   <= 1'b0;
            o_we    <= 1'b0;
            o_waddr <= '0;
            o_wdata <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= i_vsync;
            vs_qq   <= vs_q;
            o_busy  <= (state_d != IDLE);
            o_done  <= (state_q == DONE);
            o_we    <= 1'b0;
            case (state_q)
                IDLE: if (i_start) begin
                    o_err  <= 1'b0;
                    cnt_q  <= '0;
                    wdog_q <= '0;
                end
                ARM: wdog_q <= wdog_q + WD_W'(1);
                CAPTURE: begin
                    if (i_de) begin
                        o_we    <= 1'b1;
                        o_waddr <= cnt_q;
                        o_wdata <= i_data;
                        wdog_q  <= '0;
                        if (!last_pix) cnt_q <= cnt_q + ADDR_W'(1);
                    end else begin
                        wdog_q <= wdog_q + WD_W'(1);
                    end
                end
                ERR: o_err <= 1'b1;
                default: ;
            endcase
        end
    end

    logic unused_in;

`ifdef CAPTURE_STATS_EN
    logic [ADDR_W-1:0] edge_q;

    always_ff @(posedge clk) begin
        if (rst)
            edge_q <= '0;
        else if (start_ok)
            edge_q <= '0;
        else if (state_q == CAPTURE && i_de && (i_data >= 8'(EDGE_TH)))
            edge_q <= edge_q + ADDR_W'(1);
    end

    assign o_edge_cnt = edge_q;
    assign unused_in  = i_hsync;
`else
    assign o_edge_cnt = '0;
    assign unused_in  = i_hsync ^ start_ok ^ (8'(EDGE_TH) == 8'd0);
`endif

endmodule

// File: tb/tb_filter_capture_ctrl.sv
// Randomised bench for filter_capture_ctrl on a 4x2 frame with a 64-cycle watchdog.
// Observed writes are collected by a monitor and compared against the driven pixel stream.
module tb_filter_capture_ctrl;

    localparam int H_RES = 4, V_RES = 2, ADDR_W = 16, TIMEOUT_CYC = 64, EDGE_TH = 128;
    localparam int NPIX = H_RES * V_RES;

    typedef logic [7:0] frame_t [NPIX];

    logic              clk = 1'b0;
    logic              rst, i_start, i_vsync, i_hsync, i_de;
    logic [7:0]        i_data;
    logic              o_busy, o_done, o_err, o_we;
    logic [ADDR_W-1:0] o_waddr, o_edge_cnt;
    logic [7:0]        o_wdata;

    filter_capture_ctrl #(
        .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W),
        .TIMEOUT_CYC(TIMEOUT_CYC), .EDGE_TH(EDGE_TH)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .o_done(o_done),
        .o_err(o_err), .i_vsync(i_vsync), .i_hsync(i_hsync), .i_de(i_de), .i_data(i_data),
        .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata), .o_edge_cnt(o_edge_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int obs_a[$];
    int obs_d[$];
    int done_cnt, last_we_cyc, done_cyc;
    int n_chk = 0, n_pass = 0;

    always @(negedge clk) begin
        if (o_we) begin
            obs_a.push_back(int'(o_waddr));
            obs_d.push_back(int'(o_wdata));
            last_we_cyc = cyc;
        end
        if (o_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        if (n > 0) #1;
    endtask

    task automatic clear_mon();
        obs_a.delete();
        obs_d.delete();
        done_cnt = 0;
        last_we_cyc = 0;
        done_cyc = 0;
    endtask

    task automatic start_pulse();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic vsync_pulse();
        i_de    = 1'b0;
        i_vsync = 1'b1;
        step(3);
        i_vsync = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] d, input int gap);
        i_de = 1'b0;
        step(gap);
        i_de    = 1'b1;
        i_data  = d;
        i_hsync = 1'($urandom);
        step();
        i_de = 1'b0;
    endtask

    function automatic int model_edges(input frame_t f);
        int n = 0;
        for (int i = 0; i < NPIX; i++) if (int'(f[i]) >= EDGE_TH) n++;
`ifdef CAPTURE_STATS_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic run_frame(input frame_t f, input bit poke_start, input int junk);
        clear_mon();
        start_pulse();
        chk("busy_on", o_busy, 1);
        repeat (junk) begin
            i_de   = 1'b1;
            i_data = 8'($urandom);
            step();
        end
        i_de = 1'b0;
        vsync_pulse();
        for (int i = 0; i < NPIX; i++) begin
            send_pix(f[i], $urandom_range(0, 3));
            if (poke_start && i == 3) begin
                i_start = 1'b1;
                step();
                i_start = 1'b0;
            end
        end
        for (int t = 0; t < 20 && done_cnt == 0; t++) step();
        step(2);
        chk("wr_count", obs_a.size(), NPIX);
        for (int i = 0; i < NPIX && i < obs_a.size(); i++) begin
            chk("waddr", obs_a[i], i);
            chk("wdata", obs_d[i], f[i]);
        end
        chk("done_cnt", done_cnt, 1);
        chk("done_lat", done_cyc - last_we_cyc, 1);
        chk("err_clr", o_err, 0);
        chk("busy_off", o_busy, 0);
        chk("edge_cnt", o_edge_cnt, model_edges(f));
    endtask

    frame_t f;

    initial begin
        rst = 1'b1; i_start = 1'b0; i_vsync = 1'b0; i_hsync = 1'b0; i_de = 1'b0; i_data = '0;
        clear_mon();
        step(3);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_err", o_err, 0);
        chk("rst_we", o_we, 0);
        chk("rst_waddr", o_waddr, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("rst_edge", o_edge_cnt, 0);
        rst = 1'b0;
        step(2);

        // random frames, some with stray start pulses and pre-sync pixels
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NPIX; i++) f[i] = 8'($urandom);
            run_frame(f, 1'(r & 1), $urandom_range(0, 10));
            step($urandom_range(1, 4));
        end

        f = '{8'd0, 8'd255, 8'd128, 8'd127, 8'd200, 8'd0, 8'd0, 8'd255};
        run_frame(f, 1'b0, 0);

        // short frame: second vsync after five pixels
        clear_mon();
        start_pulse();
        vsync_pulse();
        for (int i = 0; i < 5; i++) send_pix(8'($urandom), 0);
        vsync_pulse();
        step(3);
        chk("short_err", o_err, 1);
        chk("short_done", done_cnt, 0);
        chk("short_busy", o_busy, 0);
        chk("short_wr", obs_a.size(), 5);
        start_pulse();
        chk("restart_err", o_err, 0);
        chk("restart_busy", o_busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // timeout with no vsync
        clear_mon();
        start_pulse();
        step(61);
        chk("to_busy_early", o_busy, 1);
        chk("to_err_early", o_err, 0);
        step(6);
        chk("to_err", o_err, 1);
        chk("to_busy", o_busy, 0);
        chk("to_we", obs_a.size(), 0);
        step(2);

        // reset in the middle of a capture
        clear_mon();
        start_pulse();
        vsync_pulse();
        for (int i = 0; i < 3; i++) send_pix(8'($urandom), 0);
        i_de   = 1'b1;
        i_data = 8'hA5;
        rst    = 1'b1;
        step();
        chk("mrst_we", o_we, 0);
        chk("mrst_busy", o_busy, 0);
        chk("mrst_done", o_done, 0);
        chk("mrst_err", o_err, 0);
        rst  = 1'b0;
        i_de = 1'b0;
        step(2);
        for (int i = 0; i < NPIX; i++) f[i] = 8'($urandom);
        run_frame(f, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1);
    end

endmodule
